// File: rtl/reg_file_wb_pkg.sv
// rtl/reg_file_wb_pkg.sv - shared register-file types and constants
//
// Purpose : widths, address type and the hardwired-zero index shared by
//           reg_file_wb and its reg_word storage cells.
// Ports   : none (package).
package reg_file_wb_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;
   localparam int REG_NREGS  = 1 << REG_ADDR_W;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [REG_DATA_W-1:0] reg_data_t;

   localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/reg_file_wb_reg_word.sv
// rtl/reg_file_wb_reg_word.sv - one load-enabled register word
//
// Purpose : single W-bit storage word, cleared by async reset, loads d_i on
//           the rising clock edge when load_i is high.
// Ports   : clk     in  clock, rising edge
//           rst     in  asynchronous active-high reset
//           load_i  in  write strobe (one-hot select bit for this word)
//           d_i     in  W-bit write data
//           q_o     out W-bit stored value
module reg_word
   import reg_file_wb_pkg::*;
#(
   parameter int W = REG_DATA_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] word_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_q <= '0;
      end else if (load_i) begin
         word_q <= d_i;
      end
   end

   assign q_o = word_q;

endmodule

// File: rtl/reg_file_wb.sv
// rtl/reg_file_wb.sv - 32x32 register file with pending-write scoreboard
//
// Purpose : architectural register file, two combinational read ports, one
//           synchronous write port, R0 hardwired to zero, plus a per-register
//           busy scoreboard (set on issue, cleared on write-back, set wins).
// Config  : define REG_FILE_WB_BYPASS_EN for write-through read bypass of
//           data and busy; default build reads stored state only.
// Ports   : clk, rst            clock / async active-high reset
//           rd_addr0/1          read indices
//           rd_data0/1          read data (combinational)
//           rd_busy0/1          pending-write flag of the read index
//           wr_en/wr_addr/wr_data  write-back port
//           iss_en/iss_addr     issue port, marks iss_addr pending
module reg_file_wb
   import reg_file_wb_pkg::*;
#(
   parameter int DATA_W = REG_DATA_W,
   parameter int NREGS  = REG_NREGS,
   parameter int ADDR_W = REG_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] rd_addr0,
   output logic [DATA_W-1:0] rd_data0,
   output logic              rd_busy0,
   input  logic [ADDR_W-1:0] rd_addr1,
   output logic [DATA_W-1:0] rd_data1,
   output logic              rd_busy1,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              iss_en,
   input  logic [ADDR_W-1:0] iss_addr
);

   logic [NREGS-1:0]  wr_sel;
   logic [NREGS-1:0]  iss_sel;
   logic [NREGS-1:0]  busy_d;
   logic [NREGS-1:0]  busy_q;
   logic [DATA_W-1:0] word_q [NREGS];

   // One-hot decodes with index 0 masked: R0 is never written nor marked busy.
   always_comb begin
      wr_sel  = '0;
      iss_sel = '0;
      if (wr_en && (wr_addr != REG_ZERO)) begin
         wr_sel[wr_addr] = 1'b1;
      end
      if (iss_en && (iss_addr != REG_ZERO)) begin
         iss_sel[iss_addr] = 1'b1;
      end
      // Clear first, then set: a new producer issued in the write-back cycle
      // of the old one keeps the register pending.
      busy_d = (busy_q & ~wr_sel) | iss_sel;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign word_q[0] = '0;

   for (genvar g = 1; g < NREGS; g++) begin : g_word
      reg_word #(
         .W (DATA_W)
      ) u_word (
         .clk    (clk),
         .rst    (rst),
         .load_i (wr_sel[g]),
         .d_i    (wr_data),
         .q_o    (word_q[g])
      );
   end

   always_comb begin
      rd_data0 = word_q[rd_addr0];
      rd_busy0 = busy_q[rd_addr0];
      rd_data1 = word_q[rd_addr1];
      rd_busy1 = busy_q[rd_addr1];
`ifdef REG_FILE_WB_BYPASS_EN
      // Forward the in-flight write; the busy view reflects what the stored
      // bit will become after this edge. Suppressed during reset so reads
      // stay zero.
      if (!rst && wr_en && (wr_addr == rd_addr0) && (rd_addr0 != REG_ZERO)) begin
         rd_data0 = wr_data;
         rd_busy0 = iss_en && (iss_addr == rd_addr0);
      end
      if (!rst && wr_en && (wr_addr == rd_addr1) && (rd_addr1 != REG_ZERO)) begin
         rd_data1 = wr_data;
         rd_busy1 = iss_en && (iss_addr == rd_addr1);
      end
`endif
   end

endmodule

// File: tb/tb_reg_file_wb.sv
// tb/tb_reg_file_wb.sv - self-checking bench for reg_file_wb
module tb_reg_file_wb;

`ifdef REG_FILE_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  rd_addr0, rd_addr1, wr_addr, iss_addr;
   logic [31:0] rd_data0, rd_data1, wr_data;
   logic        rd_busy0, rd_busy1, wr_en, iss_en;

   int checks   = 0;
   int failures = 0;

   // Reference state: architectural contents and pending flags.
   logic [31:0] m_mem  [32];
   bit          m_busy [32];

   always #5 clk = ~clk;

   reg_file_wb dut (
      .clk      (clk),
      .rst      (rst),
      .rd_addr0 (rd_addr0),
      .rd_data0 (rd_data0),
      .rd_busy0 (rd_busy0),
      .rd_addr1 (rd_addr1),
      .rd_data1 (rd_data1),
      .rd_busy1 (rd_busy1),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .iss_en   (iss_en),
      .iss_addr (iss_addr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         m_mem[i]  = '0;
         m_busy[i] = 1'b0;
      end
   endtask

   function automatic logic [31:0] exp_data(input logic [4:0] a);
      if (a == 0) return 32'h0;
      if (BYP && wr_en && wr_addr == a) return wr_data;
      return m_mem[a];
   endfunction

   function automatic logic exp_busy(input logic [4:0] a);
      if (a == 0) return 1'b0;
      if (BYP && wr_en && wr_addr == a) return iss_en && iss_addr == a;
      return m_busy[a];
   endfunction

   task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic ie, input logic [4:0] ia,
                        input logic [4:0] ra0, input logic [4:0] ra1);
      wr_en = we; wr_addr = wa; wr_data = wd;
      iss_en = ie; iss_addr = ia;
      rd_addr0 = ra0; rd_addr1 = ra1;
      #1;
   endtask

   task automatic check_model();
      chk("rd_data0", rd_data0, exp_data(rd_addr0));
      chk("rd_busy0", {31'b0, rd_busy0}, {31'b0, exp_busy(rd_addr0)});
      chk("rd_data1", rd_data1, exp_data(rd_addr1));
      chk("rd_busy1", {31'b0, rd_busy1}, {31'b0, exp_busy(rd_addr1)});
   endtask

   // Advance one edge and apply the architectural rules to the model.
   task automatic tick();
      @(posedge clk);
      if (wr_en && wr_addr != 0) m_mem[wr_addr] = wr_data;
      if (wr_en) m_busy[wr_addr] = 1'b0;
      if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
      #1;
   endtask

   task automatic step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic ie, input logic [4:0] ia,
                       input logic [4:0] ra0, input logic [4:0] ra1);
      drive(we, wa, wd, ie, ia, ra0, ra1);
      check_model();
      tick();
   endtask

   initial begin
      rst = 1'b1;
      model_reset();
      drive(0, 0, 0, 0, 0, 5, 9);
      chk("reset_data0", rd_data0, 32'h0);
      chk("reset_busy1", {31'b0, rd_busy1}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Write r5, read back next cycle; r6 untouched.
      step(1, 5, 32'hDEADBEEF, 0, 0, 5, 6);
      drive(0, 0, 0, 0, 0, 5, 6);
      check_model();
      chk("t2_rd0_r5", rd_data0, 32'hDEADBEEF);
      chk("t2_rd1_r6", rd_data1, 32'h0);
      tick();

      // R0 ignores writes and issue.
      step(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("t3_r0_data", rd_data0, 32'h0);
      chk("t3_r0_busy", {31'b0, rd_busy0}, 32'h0);
      tick();

      // Issue r7 then write it back.
      step(0, 0, 0, 1, 7, 7, 7);
      drive(0, 0, 0, 0, 0, 7, 0);
      chk("t4_busy_set", {31'b0, rd_busy0}, 32'h1);
      tick();
      step(1, 7, 32'h12, 0, 0, 7, 7);
      drive(0, 0, 0, 0, 0, 7, 7);
      chk("t4_busy_clr", {31'b0, rd_busy0}, 32'h0);
      chk("t4_data", rd_data1, 32'h12);
      tick();

      // Set wins over clear on the same register.
      step(0, 0, 0, 1, 9, 9, 1);
      step(1, 9, 32'h55, 1, 9, 9, 9);
      drive(0, 0, 0, 0, 0, 9, 9);
      check_model();
      chk("t5_data", rd_data0, 32'h55);
      chk("t5_busy", {31'b0, rd_busy1}, 32'h1);
      tick();

      // Same-cycle read of the address being written.
      step(1, 3, 32'h1111, 0, 0, 2, 3);
      drive(1, 3, 32'hA5A5, 0, 0, 3, 3);
      check_model();
      chk("t6_same_cycle", rd_data0, BYP ? 32'hA5A5 : 32'h1111);
      tick();
      drive(0, 0, 0, 0, 0, 3, 3);
      chk("t6_next_cycle", rd_data0, 32'hA5A5);
      tick();

      // Random traffic; narrow address range half the time to force collisions.
      for (int n = 0; n < 400; n++) begin
         logic [4:0] wa, ia, r0, r1;
         bit narrow;
         narrow = $urandom_range(0, 1) == 1;
         wa = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
         ia = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
         r0 = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
         r1 = ($urandom_range(0, 3) == 0) ? r0 : 5'($urandom);
         step(1'($urandom), wa, $urandom, 1'($urandom), ia, r0, r1);
      end

      // Asynchronous reset mid-cycle: state must clear without a clock edge.
      drive(0, 0, 0, 1, 4, 4, 4);
      tick();
      drive(0, 0, 0, 0, 0, 5, 4);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      for (int i = 0; i < 32; i++) begin
         rd_addr0 = 5'(i);
         rd_addr1 = 5'(31 - i);
         #1;
         chk("rst_data0", rd_data0, 32'h0);
         chk("rst_busy0", {31'b0, rd_busy0}, 32'h0);
         chk("rst_data1", rd_data1, 32'h0);
         chk("rst_busy1", {31'b0, rd_busy1}, 32'h0);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int n = 0; n < 50; n++) begin
         step(1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom),
              5'($urandom), 5'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
